// File: rtl/fiber_bank_arbiter.sv
// fiber_bank_arbiter
//   Shares one fiberBank request port among N_PE processing elements, one
//   transaction at a time. A round-robin pick on the type/addr channel chooses a
//   winner; the write-data or read-data channel is then steered between that
//   winner and the bank until the transaction completes.
// Ports
//   i_clk, i_reset                   clock, synchronous active-high reset
//   i_pe_type/addr/type_valid        per-PE request (type one-hot, PE k at [4k+:4])
//   o_pe_type_ready                  per-PE request accept (at most one bit set)
//   i_pe_data/data_valid, o_pe_data_ready     per-PE write-data channel
//   o_pe_rdata, o_pe_rdata_valid, i_pe_rdata_ready  read-data channel back to PEs
//   o_bank_type/addr/type_valid, i_bank_type_ready  request channel to bank
//   o_bank_data/data_valid, i_bank_data_ready       write channel to bank
//   i_bank_rdata/rdata_valid, o_bank_rdata_ready    read channel from bank
//   o_grant_id, o_busy, o_bad_req    status (current/last winner, busy, sticky bad type)
module fiber_bank_arbiter #(
  parameter int N_PE       = 4,
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 64
) (
  input  logic                         i_clk,
  input  logic                         i_reset,
  input  logic [4*N_PE-1:0]            i_pe_type,
  input  logic [ADDR_WIDTH*N_PE-1:0]   i_pe_addr,
  input  logic [N_PE-1:0]              i_pe_type_valid,
  output logic [N_PE-1:0]              o_pe_type_ready,
  input  logic [DATA_WIDTH*N_PE-1:0]   i_pe_data,
  input  logic [N_PE-1:0]              i_pe_data_valid,
  output logic [N_PE-1:0]              o_pe_data_ready,
  output logic [DATA_WIDTH-1:0]        o_pe_rdata,
  output logic [N_PE-1:0]              o_pe_rdata_valid,
  input  logic [N_PE-1:0]              i_pe_rdata_ready,
  output logic [3:0]                   o_bank_type,
  output logic [ADDR_WIDTH-1:0]        o_bank_addr,
  output logic                         o_bank_type_valid,
  input  logic                         i_bank_type_ready,
  output logic [DATA_WIDTH-1:0]        o_bank_data,
  output logic                         o_bank_data_valid,
  input  logic                         i_bank_data_ready,
  input  logic [DATA_WIDTH-1:0]        i_bank_rdata,
  input  logic                         i_bank_rdata_valid,
  output logic                         o_bank_rdata_ready,
  output logic [$clog2(N_PE)-1:0]      o_grant_id,
  output logic                         o_busy,
  output logic                         o_bad_req
);

  localparam int GW = $clog2(N_PE);

  localparam logic [3:0] T_FETCH   = 4'b0001;
  localparam logic [3:0] T_READ    = 4'b0010;
  localparam logic [3:0] T_WRITE   = 4'b0100;
  localparam logic [3:0] T_CONSUME = 4'b1000;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WDATA = 2'd2,
    S_RDATA = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic [GW-1:0]         gid_q, gid_d;
  logic [GW-1:0]         rr_ptr_q, rr_ptr_d;
  logic [3:0]            type_q, type_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  bad_req_q, bad_req_d;

  logic                  win_found;
  logic [GW-1:0]         win_id;

  // Per-PE views of the packed buses, so they can be indexed by grant id
  logic [3:0]            pe_type_a [N_PE];
  logic [ADDR_WIDTH-1:0] pe_addr_a [N_PE];
  logic [DATA_WIDTH-1:0] pe_data_a [N_PE];

  for (genvar k = 0; k < N_PE; k++) begin : g_unpack
    assign pe_type_a[k] = i_pe_type[4*k +: 4];
    assign pe_addr_a[k] = i_pe_addr[ADDR_WIDTH*k +: ADDR_WIDTH];
    assign pe_data_a[k] = i_pe_data[DATA_WIDTH*k +: DATA_WIDTH];
  end

  function automatic logic is_onehot4(input logic [3:0] t);
    return (t != 4'b0000) && ((t & (t - 4'b0001)) == 4'b0000);
  endfunction

  // Round-robin search: walk from the highest offset down so the last hit is
  // the first valid PE at or after rr_ptr.
  always_comb begin
    int idx;
    win_found = 1'b0;
    win_id    = rr_ptr_q;
    for (int i = N_PE - 1; i >= 0; i--) begin
      idx = (int'(rr_ptr_q) + i) % N_PE;
      if (i_pe_type_valid[idx]) begin
        win_found = 1'b1;
        win_id    = GW'(idx);
      end else begin
        win_found = win_found;
      end
    end
  end

  // State register and latched transaction fields
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q   <= S_IDLE;
      gid_q     <= '0;
      rr_ptr_q  <= '0;
      type_q    <= 4'b0000;
      addr_q    <= '0;
      bad_req_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      gid_q     <= gid_d;
      rr_ptr_q  <= rr_ptr_d;
      type_q    <= type_d;
      addr_q    <= addr_d;
      bad_req_q <= bad_req_d;
    end
  end

  // Next-state logic
  always_comb begin
    int nxt;
    state_d   = state_q;
    gid_d     = gid_q;
    rr_ptr_d  = rr_ptr_q;
    type_d    = type_q;
    addr_d    = addr_q;
    bad_req_d = bad_req_q;
    nxt       = (int'(win_id) + 1) % N_PE;
    case (state_q)
      S_IDLE: begin
        if (win_found) begin
          gid_d    = win_id;
          rr_ptr_d = GW'(nxt);
          // A malformed type is consumed but never reaches the bank
          if (is_onehot4(pe_type_a[win_id])) begin
            type_d  = pe_type_a[win_id];
            addr_d  = pe_addr_a[win_id];
            state_d = S_ISSUE;
          end else begin
            bad_req_d = 1'b1;
            state_d   = S_IDLE;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: begin
        if (i_bank_type_ready) begin
          case (type_q)
            T_WRITE:          state_d = S_WDATA;
            T_READ, T_CONSUME: state_d = S_RDATA;
            T_FETCH:          state_d = S_IDLE;
            default:          state_d = S_IDLE;
          endcase
        end else begin
          state_d = S_ISSUE;
        end
      end
      S_WDATA: begin
        if (i_pe_data_valid[gid_q] && i_bank_data_ready) state_d = S_IDLE;
        else                                             state_d = S_WDATA;
      end
      S_RDATA: begin
        if (i_bank_rdata_valid && i_pe_rdata_ready[gid_q]) state_d = S_IDLE;
        else                                               state_d = S_RDATA;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output steering; everything handshake-related is forced low while in reset
  always_comb begin
    o_pe_type_ready    = '0;
    o_pe_data_ready    = '0;
    o_pe_rdata         = '0;
    o_pe_rdata_valid   = '0;
    o_bank_type_valid  = 1'b0;
    o_bank_data        = '0;
    o_bank_data_valid  = 1'b0;
    o_bank_rdata_ready = 1'b0;
    if (i_reset) begin
      o_bank_type_valid = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (win_found) o_pe_type_ready[win_id] = 1'b1;
          else           o_pe_type_ready         = '0;
        end
        S_ISSUE: o_bank_type_valid = 1'b1;
        S_WDATA: begin
          o_bank_data             = pe_data_a[gid_q];
          o_bank_data_valid       = i_pe_data_valid[gid_q];
          o_pe_data_ready[gid_q]  = i_bank_data_ready;
        end
        S_RDATA: begin
          o_pe_rdata              = i_bank_rdata;
          o_pe_rdata_valid[gid_q] = i_bank_rdata_valid;
          o_bank_rdata_ready      = i_pe_rdata_ready[gid_q];
        end
        default: o_bank_type_valid = 1'b0;
      endcase
    end
  end

  assign o_bank_type = type_q;
  assign o_bank_addr = addr_q;
  assign o_grant_id  = gid_q;
  assign o_busy      = (state_q != S_IDLE);
  assign o_bad_req   = bad_req_q;

endmodule

// File: tb/tb_fiber_bank_arbiter.sv
module tb_fiber_bank_arbiter;

  localparam int N  = 4;
  localparam int DW = 16;
  localparam int AW = 64;

  logic            clk = 1'b0;
  logic            reset;
  logic [4*N-1:0]  pe_type;
  logic [AW*N-1:0] pe_addr;
  logic [N-1:0]    pe_tv;
  logic [N-1:0]    pe_tready;
  logic [DW*N-1:0] pe_data;
  logic [N-1:0]    pe_dv;
  logic [N-1:0]    pe_dready;
  logic [DW-1:0]   pe_rdata;
  logic [N-1:0]    pe_rvalid;
  logic [N-1:0]    pe_rready;
  logic [3:0]      bank_type;
  logic [AW-1:0]   bank_addr;
  logic            bank_tvalid;
  logic            bank_tready;
  logic [DW-1:0]   bank_data;
  logic            bank_dvalid;
  logic            bank_dready;
  logic [DW-1:0]   bank_rdata;
  logic            bank_rvalid;
  logic            bank_rready;
  logic [1:0]      grant_id;
  logic            busy;
  logic            bad_req;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fiber_bank_arbiter #(.N_PE(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .i_clk(clk), .i_reset(reset),
    .i_pe_type(pe_type), .i_pe_addr(pe_addr), .i_pe_type_valid(pe_tv),
    .o_pe_type_ready(pe_tready),
    .i_pe_data(pe_data), .i_pe_data_valid(pe_dv), .o_pe_data_ready(pe_dready),
    .o_pe_rdata(pe_rdata), .o_pe_rdata_valid(pe_rvalid), .i_pe_rdata_ready(pe_rready),
    .o_bank_type(bank_type), .o_bank_addr(bank_addr), .o_bank_type_valid(bank_tvalid),
    .i_bank_type_ready(bank_tready),
    .o_bank_data(bank_data), .o_bank_data_valid(bank_dvalid), .i_bank_data_ready(bank_dready),
    .i_bank_rdata(bank_rdata), .i_bank_rdata_valid(bank_rvalid), .o_bank_rdata_ready(bank_rready),
    .o_grant_id(grant_id), .o_busy(busy), .o_bad_req(bad_req)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are driven 1 time unit after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Step 1: reset with all PEs requesting FETCH
    reset       = 1'b1;
    pe_type     = {4'b0001, 4'b0001, 4'b0001, 4'b0001};
    pe_addr     = '0;
    for (int k = 0; k < N; k++) pe_addr[AW*k +: AW] = 64'h1000 + 64'(k);
    pe_tv       = 4'b1111;
    pe_data     = '0;
    pe_dv       = 4'b0000;
    pe_rready   = 4'b0000;
    bank_tready = 1'b1;
    bank_dready = 1'b0;
    bank_rdata  = 16'h0000;
    bank_rvalid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("rst_tready", 64'(pe_tready), 64'h0);
      chk("rst_tvalid", 64'(bank_tvalid), 64'h0);
      chk("rst_busy", 64'(busy), 64'h0);
      chk("rst_bad", 64'(bad_req), 64'h0);
      chk("rst_btype", 64'(bank_type), 64'h0);
    end
    reset = 1'b0;
    #1;

    // Step 2: round-robin FETCH, one grant every two cycles, order 0,1,2,3,0
    for (int k = 0; k < 5; k++) begin
      chk("rr_ready", 64'(pe_tready), 64'(4'b0001 << (k % 4)));
      tick();
      chk("rr_gid", 64'(grant_id), 64'(k % 4));
      chk("rr_tvalid", 64'(bank_tvalid), 64'h1);
      chk("rr_addr", bank_addr, 64'h1000 + 64'(k % 4));
      chk("rr_issue_ready", 64'(pe_tready), 64'h0);
      if (k == 4) pe_tv = 4'b0000;
      tick();
    end

    // Step 3: PE2 WRITE 0x1230 / 0xBEEF, bank write ready low for 5 cycles
    pe_type[11:8]     = 4'b0100;
    pe_addr[AW*2 +: AW] = 64'h1230;
    pe_data[DW*2 +: DW] = 16'hBEEF;
    pe_dv             = 4'b0100;
    pe_tv             = 4'b0100;
    #1;
    chk("wr_ready", 64'(pe_tready), 64'h4);
    tick();
    pe_tv = 4'b0000;
    #1;
    chk("wr_btype", 64'(bank_type), 64'h4);
    chk("wr_baddr", bank_addr, 64'h1230);
    tick();
    for (int c = 0; c < 5; c++) begin
      chk("wr_bdata", 64'(bank_data), 64'hBEEF);
      chk("wr_bdvalid", 64'(bank_dvalid), 64'h1);
      chk("wr_pdready", 64'(pe_dready), 64'h0);
      tick();
    end
    bank_dready = 1'b1;
    #1;
    chk("wr_pdready_hi", 64'(pe_dready), 64'h4);
    tick();
    chk("wr_done_busy", 64'(busy), 64'h0);
    chk("wr_done_dvalid", 64'(bank_dvalid), 64'h0);
    pe_dv       = 4'b0000;
    bank_dready = 1'b0;

    // Step 4: PE1 READ with PE read-ready held low 3 cycles
    pe_type[7:4] = 4'b0010;
    pe_tv        = 4'b0010;
    #1;
    chk("rd_ready", 64'(pe_tready), 64'h2);
    tick();
    pe_tv = 4'b0000;
    #1;
    chk("rd_btype", 64'(bank_type), 64'h2);
    tick();
    bank_rdata  = 16'h00A5;
    bank_rvalid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("rd_rvalid", 64'(pe_rvalid), 64'h2);
      chk("rd_rdata", 64'(pe_rdata), 64'h00A5);
      chk("rd_brready", 64'(bank_rready), 64'h0);
      tick();
    end
    pe_rready = 4'b0010;
    #1;
    chk("rd_brready_hi", 64'(bank_rready), 64'h1);
    tick();
    bank_rvalid = 1'b0;
    pe_rready   = 4'b0000;
    #1;
    chk("rd_done_busy", 64'(busy), 64'h0);
    chk("rd_done_rvalid", 64'(pe_rvalid), 64'h0);

    // Step 5: PE3 issues non-one-hot type 0110
    pe_type[15:12] = 4'b0110;
    pe_tv          = 4'b1000;
    #1;
    chk("bad_ready", 64'(pe_tready), 64'h8);
    tick();
    pe_tv = 4'b0000;
    #1;
    chk("bad_flag", 64'(bad_req), 64'h1);
    chk("bad_busy", 64'(busy), 64'h0);
    chk("bad_tvalid", 64'(bank_tvalid), 64'h0);
    pe_type[3:0]   = 4'b0001;
    pe_type[15:12] = 4'b0001;
    pe_tv          = 4'b1001;
    #1;
    chk("bad_next_ready", 64'(pe_tready), 64'h1);
    tick();
    pe_tv = 4'b0000;
    #1;
    chk("bad_next_gid", 64'(grant_id), 64'h0);
    chk("bad_sticky", 64'(bad_req), 64'h1);
    tick();

    // Step 6: reset while PE2 READ waits for bank read data
    pe_type[11:8] = 4'b0010;
    pe_tv         = 4'b0100;
    #1;
    chk("mr_ready", 64'(pe_tready), 64'h4);
    tick();
    pe_tv = 4'b0000;
    tick();
    chk("mr_busy", 64'(busy), 64'h1);
    pe_rready = 4'b0100;
    reset     = 1'b1;
    #1;
    chk("mr_brready_in_rst", 64'(bank_rready), 64'h0);
    tick();
    reset     = 1'b0;
    pe_rready = 4'b0000;
    pe_type   = {4'b0001, 4'b0001, 4'b0001, 4'b0001};
    pe_tv     = 4'b1010;
    #1;
    chk("mr_busy_after", 64'(busy), 64'h0);
    chk("mr_bad_after", 64'(bad_req), 64'h0);
    chk("mr_gid_after", 64'(grant_id), 64'h0);
    chk("mr_baddr_after", bank_addr, 64'h0);
    chk("mr_rvalid_after", 64'(pe_rvalid), 64'h0);
    chk("mr_rr_ptr", 64'(pe_tready), 64'h2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
